// File: rtl/nvram_upload_if.sv
// ioctl upload handshake between the HPS (master) and a core-side responder (slave).
interface nvram_upload_if;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned OFFS_W = 25;

  logic              ioctl_upload;
  logic [IDX_W-1:0]  ioctl_index;
  logic              ioctl_rd;
  logic [OFFS_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;

  modport master (output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
                  input  ioctl_din, ioctl_wait);
  modport slave  (input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
                  output ioctl_din, ioctl_wait);
endinterface

// File: rtl/nvram_upload.sv
// Serves a window of core RAM (hiscore/NVRAM) to the HPS over ioctl upload,
// pausing the CPU while serving and tracking whether the region is dirty.
module nvram_upload #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned LENGTH     = 64,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned UPL_INDEX  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              autosave,
  input  logic              osd_open,
  input  logic              cpu_wr,
  nvram_upload_if.slave     ioctl,
  output logic              upload_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic              pause_req,
  output logic              dirty
);
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned LAT_W = 2;
  localparam int unsigned CMP_W = 26;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_PAUSE, S_SERVE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pause_q, pause_d;
  logic              dirty_q, dirty_d;
  logic              served_q, served_d;
  logic              osd_q, sel_q;

  logic sel_c, sel_rise_c, osd_rise_c, in_range_c;

  assign sel_c      = ioctl.ioctl_upload & (ioctl.ioctl_index == 8'(UPL_INDEX));
  assign sel_rise_c = sel_c & ~sel_q;
  assign osd_rise_c = osd_open & ~osd_q;
  assign in_range_c = CMP_W'(ioctl.ioctl_addr) < CMP_W'(LENGTH);

  // State register; sel_q resets high so a session held across reset is not re-entered.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      din_q    <= '0;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= ADDR_W'(START_ADDR);
      pause_q  <= 1'b0;
      dirty_q  <= 1'b0;
      served_q <= 1'b0;
      osd_q    <= 1'b0;
      sel_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pause_q  <= pause_d;
      dirty_q  <= dirty_d;
      served_q <= served_d;
      osd_q    <= osd_open;
      sel_q    <= sel_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    din_d    = din_q;
    wait_d   = wait_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    dirty_d  = dirty_q;
    served_d = served_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_rise_c) begin
          state_d  = S_PAUSE;
          cnt_d    = '0;
          served_d = 1'b0;
        end else if (osd_rise_c && autosave && dirty_q) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (sel_c) begin
          state_d  = S_PAUSE;
          cnt_d    = '0;
          served_d = 1'b0;
        end
      end
      S_PAUSE: begin
        if (!sel_c) state_d = S_DONE;
        else if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_SERVE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      S_SERVE: begin
        if (!sel_c) begin
          state_d = S_DONE;
          wait_d  = 1'b0;
        end else if (wait_q) begin
          // Reads during a fetch are dropped; the in-flight byte still lands.
          if (lat_q == '0) begin
            din_d    = ram_dout;
            wait_d   = 1'b0;
            served_d = 1'b1;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end else if (ioctl.ioctl_rd) begin
          if (in_range_c) begin
            addr_d = ADDR_W'(START_ADDR) + ioctl.ioctl_addr[ADDR_W-1:0];
            wait_d = 1'b1;
            lat_d  = LAT_W'(RAM_LAT - 1);
          end else begin
            din_d = 8'hFF;
          end
        end
      end
      S_DONE: begin
        if (served_q) dirty_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cpu_wr) dirty_d = 1'b1;
    pause_d = (state_d == S_PAUSE) || (state_d == S_SERVE);
  end

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = wait_q;
  assign upload_req       = req_q;
  assign ram_addr         = addr_q;
  assign pause_req        = pause_q;
  assign dirty            = dirty_q;
endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Read-side counterpart to the ROM/DIP/hiscore download path: serves core RAM contents (hiscore/NVRAM region) back to the HPS over the ioctl upload handshake.
- Tracks a dirty flag from CPU writes to the watched region and requests an upload when the OSD opens with autosave enabled.
- Holds the CPU paused while serving so RAM is stable.
- Sits beside hps_io and the hiscore block in the emu top level, on clk_sys.

Parameters:
- ADDR_W, 10, width of core RAM address
- START_ADDR, 0, first RAM address served as upload byte 0
- LENGTH, 64, number of bytes in the upload image (1..2^ADDR_W)
- RAM_LAT, 1, RAM read latency in clk_sys cycles (1..3)
- SETTLE, 4, cycles pause_req is held before the first RAM read
- UPL_INDEX, 4, ioctl_index value this block answers

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- autosave  in  1  autosave enable (OSD option)
- osd_open  in  1  OSD visible level
- cpu_wr  in  1  CPU write strobe into the watched region (sets dirty)
- ioctl_upload  in  1  upload session active
- ioctl_index  in  8  target index of the session
- ioctl_rd  in  1  single-cycle read strobe for ioctl_addr
- ioctl_addr  in  25  byte offset requested
- ioctl_din  out  8  data returned for the last read
- ioctl_wait  out  1  high while the requested byte is not yet valid
- upload_req  out  1  one-cycle request for the HPS to start an upload
- ram_addr  out  ADDR_W  RAM read address
- ram_dout  in  8  RAM read data
- pause_req  out  1  CPU pause request
- dirty  out  1  region modified since the last completed upload

Behaviour:
- Reset (async, reset_n low): state IDLE; ioctl_din=0, ioctl_wait=0, upload_req=0, pause_req=0, dirty=0, ram_addr=START_ADDR. Reset mid-session aborts immediately. No further bytes are served until the next session start.
- dirty: set on any cpu_wr cycle. Cleared only in DONE. If cpu_wr and the DONE clear occur in the same cycle, set wins.
- Session match: sel = ioctl_upload & (ioctl_index==UPL_INDEX). Sessions with any other index are ignored entirely, and outputs stay at idle values.
- States:
  - IDLE: on osd_open rising edge (registered compare) with autosave=1 and dirty=1, pulse upload_req for exactly 1 cycle and go to REQ. If sel rises while in IDLE (user-initiated), go straight to PAUSE.
  - REQ: on sel=1, go to PAUSE. upload_req is not re-pulsed. Stays in REQ indefinitely otherwise. A new osd_open edge does not re-request.
  - PAUSE: pause_req=1. Count SETTLE cycles, then go to SERVE. If sel drops, go to DONE.
  - SERVE: pause_req=1. On ioctl_rd:
    - If ioctl_addr < LENGTH: ram_addr = START_ADDR + ioctl_addr[ADDR_W-1:0] (truncating add, wraps mod 2^ADDR_W). ioctl_wait=1 the cycle after the strobe for RAM_LAT cycles. ioctl_din is loaded from ram_dout exactly RAM_LAT cycles after ram_addr is driven, and ioctl_wait drops in that same cycle.
    - If ioctl_addr >= LENGTH: ioctl_din=8'hFF the next cycle, ioctl_wait stays 0, ram_addr unchanged.
    - An ioctl_rd arriving while ioctl_wait=1 is a protocol error. It is ignored; the in-flight byte completes.
    - sel falling goes to DONE, even with a fetch in flight; that fetch is discarded.
  - DONE: 1 cycle. Clear dirty if at least one in-range byte was served this session, else keep it. Drop pause_req, go to IDLE.
- Latency: the in-range byte is valid on ioctl_din RAM_LAT+1 cycles after the ioctl_rd cycle.
- ioctl_din holds its last value between reads.

Test Plan:
- Reset mid-SERVE (RAM_LAT=2, fetch in flight) -> next cycle all outputs 0, state IDLE. The next session requires a fresh sel rise.
- autosave=1, cpu_wr pulse, osd_open 0→1 -> dirty=1, upload_req high exactly 1 cycle. A second osd_open edge while in REQ gives no second pulse.
- Session with index 4, RAM[START_ADDR+3]=8'h5A, ioctl_rd at addr 3, RAM_LAT=1 -> after SETTLE cycles pause_req=1; ioctl_wait=1 for 1 cycle; ioctl_din=8'h5A 2 cycles after the strobe.
- ioctl_addr=LENGTH (64) -> ioctl_din=8'hFF next cycle, ioctl_wait never asserted, ram_addr unchanged.
- Session end after reads of 0..63 -> DONE clears dirty, pause_req falls 1 cycle after ioctl_upload falls. Same test with cpu_wr in the DONE cycle -> dirty stays 1.
- Session with ioctl_index=0 (ROM) -> no pause_req, no ram_addr change, upload outputs idle. START_ADDR=1020, ADDR_W=10, addr 5 -> ram_addr=1 (wrap).
